// File: rtl/change_dispenser_ctrl_if.sv
// Handshake bundle between the vending core / coin hopper and the change
// dispenser sequencer.
interface change_dispenser_ctrl_if #(
  parameter int BAL_W = 4
) ();

  logic [BAL_W-1:0] bal;
  logic             bal_valid;
  logic             refill;
  logic             coin_ack;
  logic [2:0]       eject;
  logic             busy;
  logic             done;
  logic [BAL_W-1:0] short;
  logic             fault;
  logic [2:0]       inv_empty;

  // Vending core + hopper side
  modport master (
    output bal, bal_valid, refill, coin_ack,
    input  eject, busy, done, short, fault, inv_empty
  );

  // Dispenser sequencer side
  modport slave (
    input  bal, bal_valid, refill, coin_ack,
    output eject, busy, done, short, fault, inv_empty
  );

endinterface

// File: rtl/change_dispenser_ctrl.sv
// Greedy largest-first change dispenser: ejects 5/2/1-unit coins one at a time
// against per-denomination inventory, with hopper ack timeout and shortfall report.
module change_dispenser_ctrl #(
  parameter int BAL_W    = 4,
  parameter int CNT_W    = 4,
  parameter int INV_INIT = 4,
  parameter int ACK_TO   = 8
) (
  input logic                    clk,
  input logic                    rst,
  change_dispenser_ctrl_if.slave disp
);

  localparam int TO_W = $clog2(ACK_TO);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_DONE
  } state_t;

  // Index k of the inventory array matches bit k of the one-hot eject code.
  localparam int IDX_1 = 0;
  localparam int IDX_2 = 1;
  localparam int IDX_5 = 2;

  state_t           r_state;
  logic [2:0]       r_eject;
  logic [BAL_W-1:0] r_rem;
  logic [CNT_W-1:0] r_inv [3];
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_fault;
  logic             r_done;
  logic             r_busy;
  logic [BAL_W-1:0] r_short;

  state_t           w_state_nxt;
  logic [2:0]       w_eject_nxt;
  logic [BAL_W-1:0] w_rem_nxt;
  logic [CNT_W-1:0] w_inv_nxt [3];
  logic [TO_W-1:0]  w_to_cnt_nxt;
  logic             w_fault_nxt;
  logic [BAL_W-1:0] w_short_nxt;
  logic [2:0]       w_sel;
  logic [BAL_W-1:0] w_denom;

  // Greedy pick against the remaining balance and the stock on hand.
  always_comb begin
    w_sel = 3'b000;
    if (r_rem >= BAL_W'(5) && r_inv[IDX_5] != '0) begin
      w_sel = 3'b100;
    end else if (r_rem >= BAL_W'(2) && r_inv[IDX_2] != '0) begin
      w_sel = 3'b010;
    end else if (r_rem >= BAL_W'(1) && r_inv[IDX_1] != '0) begin
      w_sel = 3'b001;
    end
  end

  always_comb begin
    case (r_eject)
      3'b100:  w_denom = BAL_W'(5);
      3'b010:  w_denom = BAL_W'(2);
      3'b001:  w_denom = BAL_W'(1);
      default: w_denom = '0;
    endcase
  end

  // NOTE: every signal gets its hold value before the case so no path through
  // the block leaves a variable unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_eject_nxt  = r_eject;
    w_rem_nxt    = r_rem;
    w_inv_nxt    = r_inv;
    w_to_cnt_nxt = r_to_cnt;
    w_fault_nxt  = r_fault;
    w_short_nxt  = r_short;

    case (r_state)
      ST_IDLE: begin
        if (disp.refill) begin
          for (int k = 0; k < 3; k++) w_inv_nxt[k] = CNT_W'(INV_INIT);
          w_fault_nxt = 1'b0;
        end
        if (disp.bal_valid) begin
          w_rem_nxt   = disp.bal;
          w_state_nxt = ST_SELECT;
        end
      end

      ST_SELECT: begin
        w_to_cnt_nxt = '0;
        if (w_sel != 3'b000) begin
          w_eject_nxt = w_sel;
          w_state_nxt = ST_EJECT;
        end else begin
          w_short_nxt = r_rem;
          w_state_nxt = ST_DONE;
        end
      end

      ST_EJECT: begin
        if (disp.coin_ack) begin
          w_rem_nxt = r_rem - w_denom;
          for (int k = 0; k < 3; k++) begin
            if (r_eject[k] && r_inv[k] != '0) w_inv_nxt[k] = r_inv[k] - CNT_W'(1);
          end
          w_eject_nxt = 3'b000;
          w_state_nxt = ST_GAP;
        end else if (r_to_cnt == TO_W'(ACK_TO - 1)) begin
          // Hopper never answered: abandon the coin, keep the remainder intact.
          w_eject_nxt = 3'b000;
          w_fault_nxt = 1'b1;
          w_short_nxt = r_rem;
          w_state_nxt = ST_DONE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end

      ST_GAP:  w_state_nxt = ST_SELECT;

      ST_DONE: w_state_nxt = ST_IDLE;

      default: begin
        w_eject_nxt = 3'b000;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers take non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_eject  <= 3'b000;
      r_rem    <= '0;
      r_to_cnt <= '0;
      r_fault  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_short  <= '0;
      // NOTE: the inventory array is reset on purpose; it models physical stock
      // and must read INV_INIT after power-up, not an arbitrary value.
      for (int k = 0; k < 3; k++) r_inv[k] <= CNT_W'(INV_INIT);
    end else begin
      r_state  <= w_state_nxt;
      r_eject  <= w_eject_nxt;
      r_rem    <= w_rem_nxt;
      r_to_cnt <= w_to_cnt_nxt;
      r_fault  <= w_fault_nxt;
      r_done   <= (w_state_nxt == ST_DONE);
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_short  <= w_short_nxt;
      r_inv    <= w_inv_nxt;
    end
  end

  assign disp.eject     = r_eject;
  assign disp.busy      = r_busy;
  assign disp.done      = r_done;
  assign disp.short     = r_short;
  assign disp.fault     = r_fault;
  assign disp.inv_empty = {r_inv[IDX_5] == '0, r_inv[IDX_2] == '0, r_inv[IDX_1] == '0};

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Self-checking bench for change_dispenser_ctrl: directed vector table, randomized
// transactions against a greedy reference model, and reset corner sequences.
module tb_change_dispenser_ctrl;

  localparam int BAL_W    = 4;
  localparam int CNT_W    = 4;
  localparam int INV_INIT = 4;
  localparam int ACK_TO   = 8;
  localparam int NEVER    = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  change_dispenser_ctrl_if #(.BAL_W(BAL_W)) disp ();

  change_dispenser_ctrl #(
    .BAL_W(BAL_W), .CNT_W(CNT_W), .INV_INIT(INV_INIT), .ACK_TO(ACK_TO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (disp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: inventory counts per denomination (index 0=1, 1=2, 2=5 units).
  int mdl_inv [3];
  bit mdl_fault;

  // Greedy change-making; seq packs coins as octal digits (4=5-unit, 2=2-unit,
  // 1=1-unit), first coin most significant. A timeout aborts on the first coin.
  task automatic model_txn(input int b, input bit rf, input bit to,
                           output logic [23:0] seq, output int sh);
    int val [3];
    int rem;
    int k;
    val = '{1, 2, 5};
    rem = b;
    seq = '0;
    if (rf) begin
      mdl_inv   = '{INV_INIT, INV_INIT, INV_INIT};
      mdl_fault = 1'b0;
    end
    for (int step = 0; step < 16; step++) begin
      k = -1;
      for (int d = 2; d >= 0; d--) begin
        if (k < 0 && rem >= val[d] && mdl_inv[d] > 0) k = d;
      end
      if (k < 0) break;
      seq = {seq[20:0], 3'(1 << k)};
      if (to) begin
        mdl_fault = 1'b1;
        break;
      end
      rem -= val[k];
      mdl_inv[k]--;
    end
    sh = rem;
  endtask

  function automatic logic [2:0] model_empty();
    return {mdl_inv[2] == 0, mdl_inv[1] == 0, mdl_inv[0] == 0};
  endfunction

  // Drives one dispense from a negedge and checks it; returns at a negedge.
  // ackd = EJECT cycles before the hopper acks minus one; >= ACK_TO means never.
  task automatic run_txn(input string tag, input int b, input bit rf, input int ackd,
                         input bit noise, input logic [23:0] exp_seq, input int exp_short,
                         input bit exp_fault, input logic [2:0] exp_empty);
    logic [23:0]      seq;
    logic [2:0]       prev;
    logic [BAL_W-1:0] sh;
    logic             flt;
    logic [2:0]       emp;
    int hi, last_hi, lat, exp_n, exp_lat;
    bit got_done, busy_ok, shape_ok, to;

    to = (ackd >= ACK_TO);
    exp_n = 0;
    for (int d = 0; d < 8; d++) if (((exp_seq >> (3 * d)) & 24'd7) != 0) exp_n++;
    exp_lat = (to && exp_n > 0) ? 1 + ACK_TO : 1 + exp_n * (ackd + 3);

    seq = '0; prev = '0; sh = '0; flt = 1'b0; emp = '0;
    hi = 0; last_hi = 0; lat = 0;
    got_done = 1'b0; busy_ok = 1'b1; shape_ok = 1'b1;

    disp.bal       = BAL_W'(b);
    disp.bal_valid = 1'b1;
    disp.refill    = rf;
    disp.coin_ack  = 1'b0;
    @(negedge clk);
    disp.bal_valid = noise;
    disp.refill    = noise;
    disp.bal       = noise ? BAL_W'(15) : BAL_W'(b);

    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      @(negedge clk);
      lat++;
      if (!disp.busy) busy_ok = 1'b0;
      if (!$onehot0(disp.eject)) shape_ok = 1'b0;
      if (disp.eject != 3'b000) begin
        if (prev == 3'b000) begin
          seq = {seq[20:0], disp.eject};
          hi  = 1;
        end else begin
          if (disp.eject != prev) shape_ok = 1'b0;
          hi++;
        end
        last_hi = hi;
      end
      prev = disp.eject;
      if (disp.done) begin
        got_done       = 1'b1;
        sh             = disp.short;
        flt            = disp.fault;
        emp            = disp.inv_empty;
        disp.bal_valid = 1'b0;
        disp.refill    = 1'b0;
        disp.coin_ack  = 1'b0;
      end else begin
        if (disp.eject != 3'b000) disp.coin_ack = (hi == ackd + 1);
        else                      disp.coin_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        disp.bal_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        disp.refill    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end

    check({tag, ".done_seen"}, 32'(got_done), 32'd1);
    check({tag, ".eject_seq"}, 32'(seq), 32'(exp_seq));
    check({tag, ".short"}, 32'(sh), 32'(exp_short));
    check({tag, ".fault"}, 32'(flt), 32'(exp_fault));
    check({tag, ".inv_empty"}, 32'(emp), 32'(exp_empty));
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, ".eject_shape"}, 32'(shape_ok), 32'd1);
    if (to && exp_n > 0) check({tag, ".eject_hold"}, 32'(last_hi), 32'(ACK_TO));

    @(negedge clk);
    check({tag, ".idle_after"}, 32'({disp.done, disp.busy}), 32'd0);
  endtask

  typedef struct {
    int          bal;
    bit          rf;
    int          ackd;
    bit          noise;
    logic [23:0] seq;
    int          sh;
    bit          flt;
    logic [2:0]  empty;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [23:0] m_seq;
    int          m_sh;
    int          b, ackd;
    bit          rf, to, noise;

    vecs[0]  = '{8,  0, 1,     0, 24'o421,     0,  0, 3'b000};
    vecs[1]  = '{5,  0, 0,     0, 24'o4,       0,  0, 3'b000};
    vecs[2]  = '{5,  0, 2,     0, 24'o4,       0,  0, 3'b000};
    vecs[3]  = '{5,  0, 0,     0, 24'o4,       0,  0, 3'b100};
    vecs[4]  = '{5,  0, 1,     0, 24'o221,     0,  0, 3'b100};
    vecs[5]  = '{6,  1, 1,     1, 24'o41,      0,  0, 3'b000};
    vecs[6]  = '{4,  0, 0,     0, 24'o22,      0,  0, 3'b000};
    vecs[7]  = '{4,  0, 1,     0, 24'o22,      0,  0, 3'b010};
    vecs[8]  = '{3,  0, 0,     0, 24'o111,     0,  0, 3'b011};
    vecs[9]  = '{3,  0, 0,     0, 24'o0,       3,  0, 3'b011};
    vecs[10] = '{7,  0, NEVER, 0, 24'o4,       7,  1, 3'b011};
    vecs[11] = '{2,  1, NEVER, 0, 24'o2,       2,  1, 3'b000};
    vecs[12] = '{1,  0, 0,     0, 24'o1,       0,  1, 3'b000};
    vecs[13] = '{0,  1, 0,     0, 24'o0,       0,  0, 3'b000};
    vecs[14] = '{15, 0, 0,     0, 24'o444,     0,  0, 3'b000};
    vecs[15] = '{15, 0, 1,     0, 24'o4222211, 0,  0, 3'b110};
    vecs[16] = '{15, 0, 2,     0, 24'o11,      13, 0, 3'b111};

    disp.bal       = '0;
    disp.bal_valid = 1'b0;
    disp.refill    = 1'b0;
    disp.coin_ack  = 1'b0;
    rst            = 1'b1;
    mdl_inv        = '{INV_INIT, INV_INIT, INV_INIT};
    mdl_fault      = 1'b0;

    @(negedge clk);
    check("reset.eject", 32'(disp.eject), 32'd0);
    check("reset.busy_done_fault", 32'({disp.busy, disp.done, disp.fault}), 32'd0);
    check("reset.short", 32'(disp.short), 32'd0);
    check("reset.inv_empty", 32'(disp.inv_empty), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table; the model tracks along so the random phase starts in sync.
    foreach (vecs[i]) begin
      model_txn(vecs[i].bal, vecs[i].rf, vecs[i].ackd >= ACK_TO, m_seq, m_sh);
      run_txn($sformatf("vec%0d", i), vecs[i].bal, vecs[i].rf, vecs[i].ackd, vecs[i].noise,
              vecs[i].seq, vecs[i].sh, vecs[i].flt, vecs[i].empty);
    end

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      b     = $urandom_range(0, 15);
      rf    = ($urandom_range(0, 3) == 0);
      to    = ($urandom_range(0, 7) == 0);
      ackd  = to ? NEVER : $urandom_range(0, 3);
      noise = 1'($urandom_range(0, 1));
      model_txn(b, rf, to, m_seq, m_sh);
      run_txn($sformatf("rnd%0d", i), b, rf, ackd, noise, m_seq, m_sh, mdl_fault, model_empty());
    end

    // Reset while a 5-unit coin awaits its ack.
    model_txn(15, 1, 0, m_seq, m_sh);
    run_txn("pre_rst", 15, 1, 0, 0, m_seq, m_sh, mdl_fault, model_empty());
    disp.bal       = BAL_W'(5);
    disp.bal_valid = 1'b1;
    @(negedge clk);
    disp.bal_valid = 1'b0;
    begin
      bit seen = 1'b0;
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
        @(negedge clk);
        if (disp.eject == 3'b100) seen = 1'b1;
      end
      check("midrst.eject_seen", 32'(seen), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("midrst.eject_drop", 32'(disp.eject), 32'd0);
    check("midrst.busy_drop", 32'(disp.busy), 32'd0);
    check("midrst.fault", 32'(disp.fault), 32'd0);
    mdl_inv   = '{INV_INIT, INV_INIT, INV_INIT};
    mdl_fault = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    begin
      bit done_seen = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
        @(negedge clk);
        if (disp.done || disp.busy) done_seen = 1'b1;
      end
      check("midrst.no_done", 32'(done_seen), 32'd0);
    end
    // Full restock is visible through the greedy choice: three 5-unit coins.
    model_txn(15, 0, 0, m_seq, m_sh);
    run_txn("post_rst", 15, 0, 0, 0, m_seq, m_sh, mdl_fault, model_empty());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser_ctrl.md
Name: change_dispenser_ctrl

Overview:
Sequences the coin hopper that returns change after a vend. The vending core hands over its balance (`bal`). This block issues one-at-a-time eject commands for 5-, 2- and 1-unit coins, using greedy largest-first selection against per-denomination inventory counters. It sits between the vending core's balance output and the hopper's eject/acknowledge interface, and reports any undispensable remainder.

Parameters:
BAL_W, 4, width of balance and remainder
CNT_W, 4, width of each inventory counter
INV_INIT, 4, count loaded into all three counters at reset and on refill
ACK_TO, 8, cycles the block waits for `coin_ack` before it aborts (must be >= 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
bal  input  BAL_W  change amount to return
bal_valid  input  1  one-cycle strobe that qualifies `bal`
refill  input  1  one-cycle strobe; reloads inventory to INV_INIT
coin_ack  input  1  hopper reports that the commanded coin was ejected
eject  output  3  one-hot eject command: bit2 = 5-unit, bit1 = 2-unit, bit0 = 1-unit
busy  output  1  high whenever the FSM is not in IDLE
done  output  1  one-cycle pulse at the end of a dispense
short  output  BAL_W  undispensed remainder; valid while `done` is high and held until the next accept
fault  output  1  sticky ack-timeout flag
inv_empty  output  3  bit k high when denomination k's counter is 0 (same bit order as `eject`)

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; `eject`, `busy`, `done`, `short`, `fault` all 0.
  - All inventory counters = INV_INIT; remainder register `rem` = 0.
- All other state changes happen on rising `clk` edges.
- States: IDLE, SELECT, EJECT, GAP, DONE. All outputs are registered.
- IDLE:
  - `bal_valid` = 1: latch `rem` = `bal`, go to SELECT.
  - `refill` = 1: counters = INV_INIT, `fault` cleared.
  - Both in the same cycle: both take effect; SELECT then sees the refilled inventory.
- SELECT (one cycle), greedy choice:
  - `rem` >= 5 and inv5 > 0: load `eject` = 3'b100, go to EJECT.
  - else `rem` >= 2 and inv2 > 0: `eject` = 3'b010.
  - else `rem` >= 1 and inv1 > 0: `eject` = 3'b001.
  - else go to DONE (covers `rem` = 0).
- EJECT:
  - `eject` is held constant.
  - `coin_ack` sampled high: `rem` -= denomination, that counter -= 1, `eject` = 0, go to GAP.
  - Timeout counter starts at 0 on entry. If ACK_TO cycles pass with no ack: `eject` = 0, `fault` = 1, go to DONE with `rem` unchanged.
- GAP: exactly one idle cycle with `eject` = 0, then go to SELECT.
- DONE (one cycle): `done` = 1, `short` = `rem`, then go to IDLE.
- `busy` is 1 in SELECT, EJECT, GAP and DONE.
- Ignored inputs:
  - `bal_valid` and `refill` whenever not in IDLE (no queuing).
  - `coin_ack` outside EJECT.
- Arithmetic:
  - `rem` never underflows, because selection guarantees `rem` >= denomination.
  - Counters never decrement below 0 and saturate at 0.
- Latency:
  - The first `eject` is visible 2 edges after `bal_valid` is sampled.
  - Each coin costs (ack wait + 2) cycles.
- Output timing:
  - `inv_empty` is combinational from the counters (registered state), so it updates the cycle after a decrement.
  - `fault` stays set until reset or an IDLE refill; `fault` does not block new dispenses.
- Reset mid-operation: `eject` drops immediately, the in-flight coin is not counted, and inventory returns to INV_INIT.

Test Plan:
- Full inventory, `bal` = 8, hopper acks 1 cycle after each eject → `eject` sequence 100, 010, 001; `done` pulse with `short` = 0; counters 3/3/3; `inv_empty` = 000.
- inv5 emptied (four prior `bal` = 5 dispenses, then `bal` = 5) → second run ejects 010, 010, 001; `short` = 0; `inv_empty[2]` = 1.
- inv1 = 0 and inv2 = 0 (after drains), `bal` = 3 → no eject; `done` with `short` = 3 two cycles after accept.
- ACK_TO = 8, `bal` = 2, `coin_ack` held 0 → `eject` = 010 for exactly 8 cycles, then drops; `fault` = 1; `short` = 2; inv2 unchanged. A later IDLE `refill` clears `fault`.
- `bal_valid` with `bal` = 6 and `refill` in the same cycle while inv5 = 0 → refill applies first; ejects 100, 001; `short` = 0. A second `bal_valid` while `busy` = 1 is ignored.
- Assert `rst` while `eject` = 100 awaits ack → `eject` = 0 and `busy` = 0 immediately; counters = INV_INIT; `done` never pulses.
